// File: rtl/b1_stream_decoder.sv
// 4-bit codeword to 3-bit symbol decoder with a one-deep output register,
// a RUN/FAULT recovery FSM and saturating ILLEGAL/AMBIGUOUS counters.
module b1_stream_decoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out_data,
   output logic [1:0] out_status,
   output logic       fault,
   output logic [7:0] err_cnt,
   output logic [7:0] amb_cnt,
   input  logic       cnt_clr
);

   typedef enum logic {S_RUN = 1'b0, S_FAULT = 1'b1} state_e;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_AMB = 2'b01;
   localparam logic [1:0] ST_ILL = 2'b10;

   state_e     state_q, state_d;
   logic [1:0] ill_run_q, ill_run_d;
   logic [1:0] ok_run_q, ok_run_d;
   logic       out_valid_q, out_valid_d;
   logic [2:0] out_data_q, out_data_d;
   logic [1:0] out_status_q, out_status_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] amb_cnt_q, amb_cnt_d;

   logic       is_ill, is_amb, is_ok;
   logic [1:0] cls;
   logic [2:0] dec;
   logic       accept, load;

   // Codeword classification and decode
   always_comb begin
      is_ill = (in_code[3] == in_code[0]) | (in_code[1] & in_code[2]);
      is_amb = !is_ill && in_code[1];
      is_ok  = !is_ill && !is_amb;
      cls    = is_ill ? ST_ILL : (is_amb ? ST_AMB : ST_OK);
      dec    = 3'b000;
      if (is_amb)
         dec = {in_code[0], in_code[0], ~in_code[0]};
      else if (is_ok)
         dec = {in_code[0], {2{in_code[2] ? ~in_code[0] : in_code[0]}}};
   end

   assign accept = in_valid && in_ready;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         ill_run_q <= 2'd0;
         ok_run_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         ill_run_q <= ill_run_d;
         ok_run_q  <= ok_run_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d   = state_q;
      ill_run_d = ill_run_q;
      ok_run_d  = ok_run_q;
      case (state_q)
         S_RUN: if (accept) begin
            if (!is_ill)
               ill_run_d = 2'd0;
            else if (ill_run_q == 2'd2) begin
               state_d   = S_FAULT;
               ill_run_d = 2'd0;
            end else
               ill_run_d = ill_run_q + 2'd1;
         end
         S_FAULT: if (accept) begin
            if (!is_ok)
               ok_run_d = 2'd0;
            else if (ok_run_q == 2'd1) begin
               state_d   = S_RUN;
               ok_run_d  = 2'd0;
               ill_run_d = 2'd0;
            end else
               ok_run_d = ok_run_q + 2'd1;
         end
         default: state_d = S_RUN;
      endcase
   end

   // FSM: outputs. FAULT always drains input; only RUN emits symbols.
   always_comb begin
      in_ready = rst_n && ((state_q == S_FAULT) || !out_valid_q || out_ready);
      load     = accept && (state_q == S_RUN);
      fault    = (state_q == S_FAULT);
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_status_d = out_status_q;
      if (load) begin
         out_valid_d  = 1'b1;
         out_data_d   = dec;
         out_status_d = cls;
      end else if (out_ready)
         out_valid_d = 1'b0;

      err_cnt_d = err_cnt_q;
      amb_cnt_d = amb_cnt_q;
      if (cnt_clr) begin
         err_cnt_d = 8'd0;
         amb_cnt_d = 8'd0;
      end else if (accept) begin
         if (is_ill && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         if (is_amb && amb_cnt_q != 8'hFF) amb_cnt_d = amb_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= 3'b000;
         out_status_q <= ST_OK;
         err_cnt_q    <= 8'd0;
         amb_cnt_q    <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_status_q <= out_status_d;
         err_cnt_q    <= err_cnt_d;
         amb_cnt_q    <= amb_cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_status = out_status_q;
   assign err_cnt    = err_cnt_q;
   assign amb_cnt    = amb_cnt_q;

endmodule
